// File: rtl/mer_meas_ctrl.sv
// mer_meas_ctrl: sequencer for the MER / symbol-error chain (calibrate, settle, measure, latch, hold).
// Optional calibration timeout with TIMEOUT state: define MER_CTRL_TIMEOUT_EN.
module mer_meas_ctrl #(
   parameter int SETTLE_SYMS  = 16,
   parameter int WIN_LOG2     = 10,
   parameter int ERR_W        = 18,
   parameter int CNT_W        = 22,
   parameter int TIMEOUT_SYMS = 4194400
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             start,
   input  logic             ack,
   input  logic             lfsr_cycle,
   input  logic [ERR_W-1:0] sq_err,
   input  logic [ERR_W-1:0] dc_err,
   input  logic             sym_err,
   output logic             ref_hold,
   output logic             acc_clear,
   output logic             meas_win,
   output logic             busy,
   output logic             result_valid,
   output logic [ERR_W-1:0] sq_err_res,
   output logic [ERR_W-1:0] dc_err_res,
   output logic [CNT_W-1:0] sym_err_cnt,
   output logic [2:0]       state_o
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CAL     = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_MEAS    = 3'd3;
   localparam logic [2:0] ST_LATCH   = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_TIMEOUT = 3'd6;

   localparam int             SET_W    = $clog2(SETTLE_SYMS + 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_SYMS - 1);

   logic [2:0]          state;
   logic [2:0]          state_nxt;
   logic [SET_W-1:0]    set_cnt;
   logic [WIN_LOG2-1:0] win_cnt;

   // Illegal settings leave an empty marker block; nothing is generated for legal ones.
   if (SETTLE_SYMS < 1 || TIMEOUT_SYMS < 1) begin : g_param_range_err
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

`ifdef MER_CTRL_TIMEOUT_EN
   localparam int            TO_W    = $clog2(TIMEOUT_SYMS + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_SYMS - 1);
   logic [TO_W-1:0] cal_cnt;
   logic            cal_expired;

   assign cal_expired = (cal_cnt == TO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cal_cnt <= '0;
      else if (clk_en)
         cal_cnt <= (state == ST_CAL) ? cal_cnt + TO_W'(1) : '0;
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_CAL;
         ST_CAL: begin
            if (lfsr_cycle)
               state_nxt = ST_SETTLE;
`ifdef MER_CTRL_TIMEOUT_EN
            else if (cal_expired)
               state_nxt = ST_TIMEOUT;
`endif
         end
         ST_SETTLE:  if (set_cnt == SET_LAST) state_nxt = ST_MEAS;
         ST_MEAS:    if (&win_cnt) state_nxt = ST_LATCH;
         ST_LATCH:   state_nxt = ST_DONE;
         ST_DONE:    if (ack) state_nxt = ST_IDLE;
`ifdef MER_CTRL_TIMEOUT_EN
         ST_TIMEOUT: if (ack) state_nxt = ST_IDLE;
`endif
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_o.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         ref_hold     <= 1'b1;
         acc_clear    <= 1'b0;
         meas_win     <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         set_cnt      <= '0;
         win_cnt      <= '0;
         sym_err_cnt  <= '0;
         sq_err_res   <= '0;
         dc_err_res   <= '0;
      end else if (clk_en) begin
         state        <= state_nxt;
         ref_hold     <= (state_nxt != ST_CAL);
         acc_clear    <= (state == ST_CAL) && (state_nxt == ST_SETTLE);
         meas_win     <= (state_nxt == ST_MEAS);
         busy         <= (state_nxt != ST_IDLE);
         result_valid <= (state_nxt == ST_DONE);
         set_cnt      <= (state == ST_SETTLE) ? set_cnt + SET_W'(1) : '0;
         win_cnt      <= (state == ST_MEAS) ? win_cnt + WIN_LOG2'(1) : '0;
         if ((state == ST_SETTLE) && (state_nxt == ST_MEAS))
            sym_err_cnt <= '0;
         else if ((state == ST_MEAS) && sym_err)
            sym_err_cnt <= sat_inc(sym_err_cnt);
         if (state == ST_LATCH) begin
            sq_err_res <= sq_err;
            dc_err_res <= dc_err;
         end
      end
   end

   assign state_o = state;

endmodule

// File: doc/mer_meas_ctrl.md
Name: mer_meas_ctrl

Overview:
Sequencer for the MER / symbol-error measurement chain (ref-level generator, squared/DC error accumulators, symbol compare). On `start` it runs four phases: calibration over one full LFSR cycle, a settle delay, a fixed-length measurement window, then result latch. It counts symbol errors during the window, freezes the results, and holds them until the consumer acknowledges. Sits beside the slicer/error blocks in the top level and replaces the free-running hold/reset wiring.

Parameters:
SETTLE_SYMS, 16, symbols to wait after calibration before measuring (min 1)
WIN_LOG2, 10, measurement window length = 2^WIN_LOG2 symbols
ERR_W, 18, width of sq/dc error inputs and result registers
CNT_W, 22, width of symbol error counter
TIMEOUT_SYMS, 4194400, calibration timeout (optional feature only)

Ports:
clk  in  1  system clock (sys_clk)
reset  in  1  asynchronous, active-low reset
clk_en  in  1  symbol enable (sym_clk_ena); all state/counters advance only when high
start  in  1  level-sampled request to begin a measurement
ack  in  1  consumer acknowledge of latched result
lfsr_cycle  in  1  one-cycle pulse at LFSR sequence wrap
sq_err  in  ERR_W  accumulated squared error from accumulator
dc_err  in  ERR_W  accumulated DC error from accumulator
sym_err  in  1  per-symbol mismatch flag, already delay-aligned
ref_hold  out  1  freeze ref-level generator
acc_clear  out  1  synchronous clear to error accumulators
meas_win  out  1  high for exactly the measured symbols
busy  out  1  high in any state except IDLE
result_valid  out  1  results held and valid
sq_err_res  out  ERR_W  latched squared error
dc_err_res  out  ERR_W  latched DC error
sym_err_cnt  out  CNT_W  symbol errors counted in window, saturating
state_o  out  3  encoded state for SignalTap

Behaviour:
- Reset (async, reset low): state IDLE; ref_hold=1, acc_clear=0, meas_win=0, busy=0, result_valid=0, all result regs and counters 0.
- States and encoding: IDLE=0, CAL=1, SETTLE=2, MEAS=3, LATCH=4, DONE=5 (6 = TIMEOUT, optional). Transitions are evaluated only on clk edges with clk_en=1; outputs are registered.
- IDLE: ref_hold=1. start=1 -> CAL.
- CAL: ref_hold=0. Remains until the first lfsr_cycle=1 sampled with clk_en=1, then -> SETTLE with ref_hold=1. An lfsr_cycle pulse with clk_en=0 is ignored.
- SETTLE: ref_hold=1. acc_clear=1 for the first enabled symbol only. Counts SETTLE_SYMS enabled symbols, then -> MEAS.
- MEAS: meas_win=1. The window counter counts 2^WIN_LOG2 enabled symbols. sym_err_cnt increments when sym_err=1 and clk_en=1, and saturates at 2^CNT_W-1. After the last symbol -> LATCH.
- LATCH: one enabled symbol. sq_err_res and dc_err_res capture their inputs, then -> DONE with result_valid=1.
- DONE: result_valid=1 and results are stable. ack=1 -> IDLE, result_valid=0 on the same edge. Results persist until the next LATCH.
- start while busy: ignored. start held high through DONE+ack: a new run begins on the next enabled edge after IDLE, giving back-to-back operation.
- ack outside DONE: ignored.
- Latency: start to result_valid = (cycles to next lfsr wrap) + SETTLE_SYMS + 2^WIN_LOG2 + 2 enabled symbols.
- sym_err_cnt clears on entry to MEAS, not on ack.
- Reset asserted mid-run: immediate return to IDLE; partial results discarded; result regs read 0.

Optional Feature:
- Macro: MER_CTRL_TIMEOUT_EN.
- With the macro defined: a CAL-phase counter of enabled symbols runs. Reaching TIMEOUT_SYMS without an lfsr_cycle pulse -> TIMEOUT state:
  - busy=1, result_valid=0, state_o=6, ref_hold=1.
  - Only ack returns to IDLE.
- Without the macro: no counter and no TIMEOUT state; CAL waits indefinitely.

Test Plan:
1. Reset low for 3 clk, then release -> all outputs 0 except ref_hold=1; state_o=0.
2. clk_en every 32 clk, start pulse, lfsr_cycle after 5 symbols, SETTLE_SYMS=4, WIN_LOG2=3 -> ref_hold low 5 symbols; acc_clear one symbol; meas_win exactly 8 symbols; result_valid after 8+4+5+2 symbols.
3. Window with sym_err=1 on 3 of 8 symbols, sq_err=0x00123 and dc_err=0x3FFF0 at LATCH -> sym_err_cnt=3, sq_err_res=0x00123, dc_err_res=0x3FFF0, held until ack.
4. CNT_W=2, sym_err=1 for all 8 window symbols -> sym_err_cnt saturates at 3.
5. Reset low during MEAS -> same edge: state 0, meas_win=0, result_valid=0; a later start runs a clean cycle.
6. MER_CTRL_TIMEOUT_EN defined, TIMEOUT_SYMS=10, no lfsr_cycle -> state_o=6 after 10 symbols; ack -> IDLE. Same stimulus without the macro -> stays in CAL.
